// File: rtl/mu0_ctrl_fsm.sv
// rtl/mu0_ctrl_fsm.sv - MU0 fetch/execute control unit with Mem_Rdy handshake and bus watchdog
module mu0_ctrl_fsm #(
    parameter int WAIT_LIMIT = 15,
    parameter int CW         = 8
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [3:0] F,
    input  logic       N,
    input  logic       Z,
    input  logic       Mem_Rdy,
    output logic       Fetch,
    output logic       Halted,
    output logic       Bus_Err,
    output logic       Acc_En,
    output logic       PC_En,
    output logic       IR_En,
    output logic       X_sel,
    output logic       Y_sel,
    output logic       Addr_sel,
    output logic [1:0] ALU_fn,
    output logic       Mem_Rd,
    output logic       Mem_Wr
);

    typedef enum logic [1:0] {FETCH, EXEC, HALT} state_t;

    localparam logic [3:0] OP_LDA = 4'd0;
    localparam logic [3:0] OP_STA = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd3;
    localparam logic [3:0] OP_JMP = 4'd4;
    localparam logic [3:0] OP_JGE = 4'd5;
    localparam logic [3:0] OP_JNE = 4'd6;
    localparam logic [3:0] OP_STP = 4'd7;

    state_t        state;
    logic [CW-1:0] wcnt;
    logic          bus_err_q;
    logic          mem_op;
    logic          req;
    logic          timeout;

    // Opcodes 0..3 are the ones that touch memory during EXEC
    assign mem_op  = (state == EXEC) && (F[3:2] == 2'b00);
    assign req     = (state == FETCH) || mem_op;
    assign timeout = req && !Mem_Rdy && (wcnt == CW'(WAIT_LIMIT));

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= FETCH;
            wcnt      <= '0;
            bus_err_q <= 1'b0;
        end else begin
            case (state)
                FETCH, EXEC: begin
                    if (req && !Mem_Rdy) begin
                        if (timeout) begin
                            state     <= HALT;
                            wcnt      <= '0;
                            bus_err_q <= 1'b1;
                        end else begin
                            wcnt <= wcnt + CW'(1);
                        end
                    end else begin
                        wcnt <= '0;
                        if (state == FETCH)
                            state <= EXEC;
                        else if (F == OP_STP)
                            state <= HALT;
                        else
                            state <= FETCH;
                    end
                end
                default: state <= HALT;
            endcase
        end
    end

    always_comb begin
        Fetch    = 1'b0;
        Halted   = 1'b0;
        Bus_Err  = 1'b0;
        Acc_En   = 1'b0;
        PC_En    = 1'b0;
        IR_En    = 1'b0;
        X_sel    = 1'b0;
        Y_sel    = 1'b0;
        Addr_sel = 1'b0;
        ALU_fn   = 2'b00;
        Mem_Rd   = 1'b0;
        Mem_Wr   = 1'b0;
        // Outputs are forced low for the whole time Reset is held
        if (!Reset) begin
            Bus_Err = bus_err_q;
            case (state)
                FETCH: begin
                    Fetch  = 1'b1;
                    Mem_Rd = 1'b1;
                    if (Mem_Rdy) begin
                        IR_En  = 1'b1;
                        PC_En  = 1'b1;
                        X_sel  = 1'b1;
                        ALU_fn = 2'b10;
                    end
                end
                EXEC: begin
                    case (F)
                        OP_LDA, OP_ADD, OP_SUB: begin
                            Mem_Rd   = 1'b1;
                            Addr_sel = 1'b1;
                            Acc_En   = Mem_Rdy;
                            ALU_fn   = (F == OP_LDA) ? 2'b00 :
                                       (F == OP_ADD) ? 2'b01 : 2'b11;
                        end
                        OP_STA: begin
                            Mem_Wr   = 1'b1;
                            Addr_sel = 1'b1;
                        end
                        OP_JMP: begin
                            PC_En = 1'b1;
                            Y_sel = 1'b1;
                        end
                        OP_JGE: begin
                            PC_En = ~N;
                            Y_sel = 1'b1;
                        end
                        OP_JNE: begin
                            PC_En = ~Z;
                            Y_sel = 1'b1;
                        end
                        default: ;
                    endcase
                end
                default: Halted = 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_mu0_ctrl_fsm.sv
// tb/tb_mu0_ctrl_fsm.sv - self-checking bench for mu0_ctrl_fsm against a transaction-level model
module tb_mu0_ctrl_fsm;
    localparam int WL = 15;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic [3:0] F = 4'd0;
    logic       N = 1'b0;
    logic       Z = 1'b0;
    logic       Mem_Rdy = 1'b0;
    logic       Fetch, Halted, Bus_Err, Acc_En, PC_En, IR_En;
    logic       X_sel, Y_sel, Addr_sel, Mem_Rd, Mem_Wr;
    logic [1:0] ALU_fn;
    logic [13:0] obs;

    int tests = 0;
    int fails = 0;

    mu0_ctrl_fsm #(.WAIT_LIMIT(WL), .CW(8)) dut (
        .Clk(Clk), .Reset(Reset), .F(F), .N(N), .Z(Z), .Mem_Rdy(Mem_Rdy),
        .Fetch(Fetch), .Halted(Halted), .Bus_Err(Bus_Err), .Acc_En(Acc_En),
        .PC_En(PC_En), .IR_En(IR_En), .X_sel(X_sel), .Y_sel(Y_sel),
        .Addr_sel(Addr_sel), .ALU_fn(ALU_fn), .Mem_Rd(Mem_Rd), .Mem_Wr(Mem_Wr)
    );

    always #5 Clk = ~Clk;

    assign obs = {Fetch, Halted, Bus_Err, Acc_En, PC_En, IR_En, X_sel, Y_sel,
                  Addr_sel, ALU_fn, Mem_Rd, Mem_Wr};

    function automatic logic [13:0] mk(input logic fe, ha, er, ac, pc, ir, xs, ys, as,
                                       input logic [1:0] fn, input logic rd, wr);
        return {fe, ha, er, ac, pc, ir, xs, ys, as, fn, rd, wr};
    endfunction

    function automatic logic [13:0] v_fetch(input logic rdy);
        return rdy ? mk(1, 0, 0, 0, 1, 1, 1, 0, 0, 2'b10, 1, 0)
                   : mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 0);
    endfunction

    function automatic logic [13:0] v_exec(input logic [3:0] f, input logic n, z, rdy);
        case (f)
            4'd0:    return mk(0, 0, 0, rdy, 0, 0, 0, 0, 1, 2'b00, 1, 0);
            4'd1:    return mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 1);
            4'd2:    return mk(0, 0, 0, rdy, 0, 0, 0, 0, 1, 2'b01, 1, 0);
            4'd3:    return mk(0, 0, 0, rdy, 0, 0, 0, 0, 1, 2'b11, 1, 0);
            4'd4:    return mk(0, 0, 0, 0, 1, 0, 0, 1, 0, 2'b00, 0, 0);
            4'd5:    return mk(0, 0, 0, 0, ~n, 0, 0, 1, 0, 2'b00, 0, 0);
            4'd6:    return mk(0, 0, 0, 0, ~z, 0, 0, 1, 0, 2'b00, 0, 0);
            default: return 14'd0;
        endcase
    endfunction

    function automatic logic [13:0] v_halt(input logic err);
        return mk(0, 1, err, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    endfunction

    task automatic check(input logic [13:0] exp, input string tag);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Drive one clock cycle: inputs just after posedge, sample at negedge
    task automatic step(input logic [3:0] f, input logic n, z, rdy,
                        input logic [13:0] exp, input string tag);
        F = f; N = n; Z = z; Mem_Rdy = rdy;
        @(negedge Clk);
        check(exp, tag);
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        Mem_Rdy = 1'b1;
        @(negedge Clk);
        check(14'd0, "reset_outputs");
        @(posedge Clk);
        #1;
        Reset = 1'b0;
    endtask

    task automatic halt_cycles(input int k, input logic err);
        for (int i = 0; i < k; i++)
            step(4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom), 1'($urandom),
                 v_halt(err), "halt");
    endtask

    // One instruction as a transaction: fetch with fw waits, exec with ew waits
    task automatic run_instr(input logic [3:0] f, input logic n, z, input int fw, ew,
                             output logic hlt, output logic err);
        logic r;
        int   i;
        hlt = 1'b0;
        err = 1'b0;
        i = 0;
        while (1) begin
            r = (i >= fw);
            step(4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom), r, v_fetch(r), "fetch");
            if (r) break;
            if (i == WL) begin
                hlt = 1'b1;
                err = 1'b1;
                return;
            end
            i++;
        end
        if (f < 4'd4) begin
            i = 0;
            while (1) begin
                r = (i >= ew);
                step(f, n, z, r, v_exec(f, n, z, r), "exec_mem");
                if (r) break;
                if (i == WL) begin
                    hlt = 1'b1;
                    err = 1'b1;
                    return;
                end
                i++;
            end
        end else begin
            r = 1'($urandom);
            step(f, n, z, r, v_exec(f, n, z, r), "exec_one");
            if (f == 4'd7) hlt = 1'b1;
        end
    endtask

    function automatic int pick_wait();
        int r;
        r = $urandom_range(0, 19);
        if (r < 12)  return 0;
        if (r < 17)  return $urandom_range(1, 3);
        if (r == 17) return WL;
        if (r == 18) return WL - 1;
        return WL + 1;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic hlt, err;

        // reset state with Mem_Rdy high must still show all outputs low
        Mem_Rdy = 1'b1;
        @(negedge Clk);
        check(14'd0, "reset_hold");
        @(posedge Clk);
        #1;
        Reset = 1'b0;

        // LDA with zero-wait memory
        step(4'd0, 0, 0, 1, mk(1, 0, 0, 0, 1, 1, 1, 0, 0, 2'b10, 1, 0), "lda_fetch");
        step(4'd0, 0, 0, 1, mk(0, 0, 0, 1, 0, 0, 0, 0, 1, 2'b00, 1, 0), "lda_exec");

        // JGE not taken then taken
        run_instr(4'd5, 1'b1, 1'b0, 0, 0, hlt, err);
        run_instr(4'd5, 1'b0, 1'b0, 0, 0, hlt, err);
        run_instr(4'd6, 1'b0, 1'b1, 0, 0, hlt, err);

        // STA with three exec waits
        run_instr(4'd1, 1'b0, 1'b0, 0, 3, hlt, err);

        // SUB then STP, halted for 20 cycles
        run_instr(4'd3, 1'b0, 1'b0, 0, 0, hlt, err);
        run_instr(4'd7, 1'b0, 1'b0, 0, 0, hlt, err);
        tests++;
        assert (hlt === 1'b1 && err === 1'b0) else begin
            fails++;
            $error("FAIL stp_model: observed %b%b expected 10", hlt, err);
        end
        halt_cycles(20, 1'b0);
        do_reset();

        // Fetch stuck low until the watchdog fires, then a Mem_Rdy pulse is ignored
        run_instr(4'd0, 1'b0, 1'b0, 1000, 0, hlt, err);
        step(4'd0, 0, 0, 1, v_halt(1'b1), "halt_rdy_pulse");
        halt_cycles(3, 1'b1);
        do_reset();

        // Limit boundary: ready on the last allowed cycle completes normally
        run_instr(4'd2, 1'b0, 1'b0, WL, WL, hlt, err);

        // Asynchronous reset while ADD waits in EXEC
        step(4'd2, 0, 0, 1, v_fetch(1'b1), "add_fetch");
        step(4'd2, 0, 0, 0, v_exec(4'd2, 0, 0, 0), "add_wait");
        F = 4'd2; Mem_Rdy = 1'b0;
        @(negedge Clk);
        check(v_exec(4'd2, 0, 0, 0), "add_wait2");
        Reset = 1'b1;
        #1;
        check(14'd0, "async_reset");
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        step(4'd0, 0, 0, 0, v_fetch(1'b0), "restart_fetch");

        // Randomized instruction stream
        for (int k = 0; k < 300; k++) begin
            logic [3:0] f;
            f = 4'($urandom_range(0, 15));
            run_instr(f, 1'($urandom), 1'($urandom), pick_wait(), pick_wait(), hlt, err);
            if (hlt) begin
                halt_cycles(3, err);
                do_reset();
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
